// File: rtl/geo_ram_sched.sv
// GeoRAM backing-RAM scheduler: on each PHI2 edge it chooses between a C64
// window access, a refresh cycle or idle, and keeps track of refresh debt.
module geo_ram_sched #(
    parameter int REF_INTERVAL = 15,
    parameter int MAX_PEND     = 8,
    parameter int ROW_BITS     = 9
) (
    input  logic        PHI2,
    input  logic        nRESET,
    input  logic        WinSEL,
    input  logic        nWE,
    input  logic [7:0]  A,
    input  logic [7:0]  Block,
    input  logic [5:0]  Window,
    output logic [21:0] RamA,
    output logic        RamCE,
    output logic        RamWE,
    output logic        RamRef,
    output logic [3:0]  Pending,
    output logic        RefOverrun
);

    localparam int CNT_W = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CPU_RD,
        CPU_WR,
        REFRESH,
        RECOVER
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    interval_cnt;
    logic [ROW_BITS-1:0] ref_row;
    logic                credit;
    logic                issue;

    assign credit = (interval_cnt == CNT_W'(REF_INTERVAL - 1));
    assign issue  = (state_nxt == REFRESH);

    always_comb begin
        state_nxt = IDLE;
        if (WinSEL) begin
            state_nxt = nWE ? CPU_RD : CPU_WR;
        end else if (state != REFRESH && Pending != 4'd0) begin
            state_nxt = REFRESH;
        end else if (state == REFRESH) begin
            state_nxt = RECOVER;
        end
    end

    always_ff @(posedge PHI2 or negedge nRESET) begin
        if (!nRESET) begin
            state        <= IDLE;
            interval_cnt <= '0;
            ref_row      <= '0;
            Pending      <= 4'd0;
            RefOverrun   <= 1'b0;
        end else begin
            state        <= state_nxt;
            interval_cnt <= credit ? '0 : interval_cnt + CNT_W'(1);
            // Every exit from REFRESH advances the row, whether to RECOVER or a CPU access.
            if (state == REFRESH) begin
                ref_row <= ref_row + ROW_BITS'(1);
            end
            if (credit && !issue) begin
                if (Pending == 4'(MAX_PEND)) begin
                    RefOverrun <= 1'b1;
                end else begin
                    Pending <= Pending + 4'd1;
                end
            end else if (issue && !credit) begin
                Pending <= Pending - 4'd1;
            end
        end
    end

    // RAM pins are registered alongside the state; the address holds through idle cycles.
    always_ff @(posedge PHI2 or negedge nRESET) begin
        if (!nRESET) begin
            RamA   <= '0;
            RamCE  <= 1'b0;
            RamWE  <= 1'b0;
            RamRef <= 1'b0;
        end else begin
            RamCE  <= 1'b0;
            RamWE  <= 1'b0;
            RamRef <= 1'b0;
            case (state_nxt)
                CPU_RD, CPU_WR: begin
                    RamA  <= {Block, Window, A};
                    RamCE <= 1'b1;
                    RamWE <= (state_nxt == CPU_WR);
                end
                REFRESH: begin
                    RamA   <= {{(22 - ROW_BITS){1'b0}}, ref_row};
                    RamCE  <= 1'b1;
                    RamRef <= 1'b1;
                end
                default: begin
                    RamA <= RamA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_geo_ram_sched.sv
// Directed bench for geo_ram_sched: refresh cadence, CPU accesses, debt
// saturation, CPU preemption of RECOVER, row wrap and async reset.
module tb_geo_ram_sched;

    logic        PHI2 = 1'b0;
    logic        nRESET = 1'b0;
    logic        WinSEL = 1'b0;
    logic        nWE = 1'b1;
    logic [7:0]  A = 8'h00;
    logic [7:0]  Block = 8'h00;
    logic [5:0]  Window = 6'h00;
    logic [21:0] RamA;
    logic        RamCE, RamWE, RamRef, RefOverrun;
    logic [3:0]  Pending;

    logic        win_b = 1'b0;
    logic        nwe_b = 1'b1;
    logic [7:0]  a_b = 8'h00;
    logic [7:0]  blk_b = 8'h00;
    logic [5:0]  wnd_b = 6'h00;
    logic [21:0] ram_a_b;
    logic        ce_b, we_b, ref_b, ovr_b;
    logic [3:0]  pend_b;

    int total = 0;
    int bad = 0;
    int edge_n = 0;

    geo_ram_sched #(.REF_INTERVAL(15), .MAX_PEND(8), .ROW_BITS(9)) dut (
        .PHI2(PHI2), .nRESET(nRESET), .WinSEL(WinSEL), .nWE(nWE), .A(A),
        .Block(Block), .Window(Window), .RamA(RamA), .RamCE(RamCE),
        .RamWE(RamWE), .RamRef(RamRef), .Pending(Pending), .RefOverrun(RefOverrun)
    );

    geo_ram_sched #(.REF_INTERVAL(4), .MAX_PEND(8), .ROW_BITS(2)) dut_b (
        .PHI2(PHI2), .nRESET(nRESET), .WinSEL(win_b), .nWE(nwe_b), .A(a_b),
        .Block(blk_b), .Window(wnd_b), .RamA(ram_a_b), .RamCE(ce_b),
        .RamWE(we_b), .RamRef(ref_b), .Pending(pend_b), .RefOverrun(ovr_b)
    );

    always #5 PHI2 = ~PHI2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PHI2);
        #1;
        edge_n++;
    endtask

    task automatic do_reset();
        WinSEL = 1'b0;
        nWE    = 1'b1;
        nRESET = 1'b0;
        #12;
        @(negedge PHI2);
        nRESET = 1'b1;
        edge_n = 0;
    endtask

    task automatic tick_to(input int target);
        while (edge_n < target) tick();
    endtask

    initial begin
        int rows_b[$];
        int ref_cnt;
        logic prev_ref;

        // Reset state
        nRESET = 1'b0;
        #3;
        check("rst_rama", RamA, 0);
        check("rst_ce", RamCE, 0);
        check("rst_we", RamWE, 0);
        check("rst_ref", RamRef, 0);
        check("rst_pend", Pending, 0);
        check("rst_ovr", RefOverrun, 0);

        // Idle refresh cadence: credit on edge 15, refresh on 16 + 15k
        do_reset();
        for (int e = 1; e <= 106; e++) begin
            tick();
            check("idle_ref", RamRef, ((e >= 16) && ((e - 16) % 15 == 0)) ? 1 : 0);
            check("idle_ce", RamCE, ((e >= 16) && ((e - 16) % 15 == 0)) ? 1 : 0);
            if (e >= 16 && (e - 16) % 15 == 0) check("idle_row", RamA, (e - 16) / 15);
            if (e == 15) check("pend_e15", Pending, 1);
            if (e == 16) check("pend_e16", Pending, 0);
            if (ref_b && rows_b.size() < 5) rows_b.push_back(int'(ram_a_b));
        end
        check("rowb_cnt", rows_b.size(), 5);
        for (int i = 0; i < 5 && i < rows_b.size(); i++) begin
            check("rowb_seq", rows_b[i], (i == 4) ? 0 : i);
        end

        // CPU write / read and block change between accesses
        do_reset();
        Block = 8'hA5; Window = 6'h3C; A = 8'h7E; WinSEL = 1'b1; nWE = 1'b0;
        tick();
        check("wr_rama", RamA, {10'd0, 8'hA5, 6'h3C, 8'h7E});
        check("wr_ce", RamCE, 1);
        check("wr_we", RamWE, 1);
        check("wr_ref", RamRef, 0);
        WinSEL = 1'b0; nWE = 1'b1; Block = 8'h5A;
        tick();
        check("idle_ce2", RamCE, 0);
        check("hold_rama", RamA, {10'd0, 8'hA5, 6'h3C, 8'h7E});
        WinSEL = 1'b1;
        tick();
        check("rd_rama", RamA, {10'd0, 8'h5A, 6'h3C, 8'h7E});
        check("rd_ce", RamCE, 1);
        check("rd_we", RamWE, 0);
        WinSEL = 1'b0;

        // Continuous WinSEL: debt saturates, then drains with RECOVER gaps
        do_reset();
        WinSEL = 1'b1;
        ref_cnt = 0;
        for (int e = 1; e <= 136; e++) begin
            tick();
            if (RamRef) ref_cnt++;
            if (e == 120) check("sat_pend120", Pending, 8);
            if (e == 134) check("sat_ovr134", RefOverrun, 0);
            if (e == 135) check("sat_ovr135", RefOverrun, 1);
        end
        check("sat_noref", ref_cnt, 0);
        check("sat_pend136", Pending, 8);
        WinSEL = 1'b0;
        ref_cnt = 0;
        prev_ref = 1'b0;
        for (int e = 137; e <= 154; e++) begin
            tick();
            if (RamRef) ref_cnt++;
            check("drain_ref", RamRef, (e % 2 == 1 && e <= 153) ? 1 : 0);
            check("drain_adj", prev_ref & RamRef, 0);
            prev_ref = RamRef;
        end
        check("drain_cnt", ref_cnt, 9);
        check("drain_pend", Pending, 0);
        check("drain_ovr", RefOverrun, 1);

        // CPU access preempts RECOVER; refresh resumes on the next idle cycle
        do_reset();
        WinSEL = 1'b1;
        tick_to(45);
        check("pre_pend45", Pending, 3);
        WinSEL = 1'b0;
        for (int e = 46; e <= 52; e++) begin
            WinSEL = (e == 47 || e == 49 || e == 51);
            tick();
            check("pre_ref", RamRef, (e == 46 || e == 48 || e == 50) ? 1 : 0);
            check("pre_ce", RamCE, (e == 52) ? 0 : 1);
        end
        WinSEL = 1'b0;
        check("pre_pend", Pending, 0);

        // Asynchronous reset during REFRESH
        do_reset();
        tick_to(16);
        check("ar_inref", RamRef, 1);
        #2;
        nRESET = 1'b0;
        #1;
        check("ar_ce", RamCE, 0);
        check("ar_ref", RamRef, 0);
        check("ar_pend", Pending, 0);
        @(negedge PHI2);
        nRESET = 1'b1;
        edge_n = 0;
        tick_to(15);
        check("ar_pend15", Pending, 1);
        check("ar_noref", RamRef, 0);
        tick();
        check("ar_ref16", RamRef, 1);
        check("ar_row0", RamA, 0);
        check("ar_ovr", RefOverrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
